// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit order,
// hex glyph table and divider/width helpers.
package seg7_pkg;

    // Bit positions of each segment inside a {g,f,e,d,c,b,a} vector.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Clocks per scan slot.
    function automatic int scan_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Nibble to active-high {g,f,e,d,c,b,a} glyph.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side bus of the scan driver: display data, load strobe and status.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic                    load;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output value, dp_in, digit_en, blank_lz, load,
        input  pending, frame_done
    );

    modport slave (
        input  value, dp_in, digit_en, blank_lz, load,
        output pending, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver_clk_tick_gen.sv
// Free-running prescaler producing a one-cycle enable every CLK_HZ/TICK_HZ
// clocks. Everything downstream stays on the input clock.
module clk_tick_gen
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int DIV   = scan_div(CLK_HZ, TICK_HZ);
    localparam int CNT_W = width_of(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(DIV - 1));

    // Count 0..DIV-1 and wrap on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: double-buffered digit data,
// leading-zero blanking and an all-anodes-off dead time after each advance.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    seg7_scan_driver_if.slave     bus,
    output logic                  CA,
    output logic                  CB,
    output logic                  CC,
    output logic                  CD,
    output logic                  CE,
    output logic                  CF,
    output logic                  CG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] AN
);
    localparam int IDX_W  = width_of(NUM_DIGITS);
    localparam int DEAD_W = width_of(BLANK_CYCLES + 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
        logic                    blank_lz;
    } frame_cfg_t;

    logic              tick;
    logic              frame_done;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [DEAD_W-1:0] dead_cnt, dead_next;
    frame_cfg_t        bus_cfg, staging, active, active_view;
    logic              pending_q;

    logic [NUM_DIGITS-1:0] lz_dark;
    logic [3:0]            nib;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [6:0]            seg_q;

    clk_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (SCAN_HZ)
    ) u_tick (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .tick  (tick)
    );

    assign bus_cfg = '{value: bus.value, dp: bus.dp_in, en: bus.digit_en,
                       blank_lz: bus.blank_lz};

    assign frame_done = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign idx_next   = !tick ? idx : (frame_done ? '0 : idx + IDX_W'(1));
    assign dead_next  = tick ? DEAD_W'(BLANK_CYCLES)
                             : ((dead_cnt != '0) ? dead_cnt - DEAD_W'(1) : '0);

    // Frame that will be on display after this edge; a load coinciding with
    // the frame boundary bypasses staging.
    assign active_view = !frame_done ? active : (bus.load ? bus_cfg : staging);

    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done;

    // Digit index and dead-time countdown.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            idx      <= '0;
            dead_cnt <= '0;
        end else begin
            idx      <= idx_next;
            dead_cnt <= dead_next;
        end
    end

    // Staging captures every load; active swaps only at the frame boundary.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        // NOTE: these buffers are plain flops, not RAM, so they take the reset.
        if (!CPU_RESETN) begin
            staging   <= '0;
            active    <= '0;
            pending_q <= 1'b0;
        end else begin
            if (bus.load) staging <= bus_cfg;
            active <= active_view;
            if (frame_done)    pending_q <= 1'b0;
            else if (bus.load) pending_q <= 1'b1;
        end
    end

    // Digit i is blanked when it and every digit above it hold zero.
    always_comb begin : lz_scan
        logic upper_zero;
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        upper_zero = 1'b1;
        lz_dark    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (active_view.value[4*i +: 4] == 4'h0);
            if (i > 0) lz_dark[i] = active_view.blank_lz && upper_zero;
        end
    end

    // Next anode/segment pattern for the digit that owns the upcoming cycle.
    always_comb begin
        nib      = active_view.value[4*int'(idx_next) +: 4];
        lit      = active_view.en[idx_next] && !lz_dark[idx_next] && (dead_next == '0);
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (lit) begin
            an_next[idx_next] = 1'b0;
            seg_next          = ~hex7(nib);
            dp_next           = ~active_view.dp[idx_next];
        end
    end

    // Registered pad drivers; reset forces everything dark.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            AN    <= '1;
            seg_q <= 7'h7F;
            DP    <= 1'b1;
        end else begin
            AN    <= an_next;
            seg_q <= seg_next;
            DP    <= dp_next;
        end
    end

    assign CA = seg_q[SEG_A];
    assign CB = seg_q[SEG_B];
    assign CC = seg_q[SEG_C];
    assign CD = seg_q[SEG_D];
    assign CE = seg_q[SEG_E];
    assign CF = seg_q[SEG_F];
    assign CG = seg_q[SEG_G];
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 10-clock slots, 2-clock dead time.
module tb_seg7_scan_driver;
    localparam int ND = 4;

    localparam logic [6:0] HEX_SHAPE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst_n;
    logic ca, cb, cc, cd, ce, cf, cg, dp;
    logic [ND-1:0] an;
    logic [6:0] seg_obs;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign seg_obs = {cg, cf, ce, cd, cc, cb, ca};

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .bus        (bus),
        .CA (ca), .CB (cb), .CC (cc), .CD (cd),
        .CE (ce), .CF (cf), .CG (cg), .DP (dp),
        .AN (an)
    );

    // At most one anode may be low in any cycle.
    always @(negedge clk) begin
        assert ($onehot0(~an)) else begin
            failures++;
            $display("FAIL an_onehot: AN=%b required one-hot-low or all-1", an);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_load(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] e, input logic b);
        bus.value    = v;
        bus.dp_in    = d;
        bus.digit_en = e;
        bus.blank_lz = b;
        bus.load     = 1'b1;
    endtask

    // Waits for a frame_done cycle; reports cycles waited and whether any anode lit.
    task automatic wait_frame_done(output int n, output logic saw_light);
        n = 0;
        saw_light = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (an !== 4'hF) saw_light = 1'b1;
            if (bus.frame_done === 1'b1) break;
        end
        checks++;
        if (bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL frame_done_timeout: frame_done=%b after %0d cycles, required 1",
                     bus.frame_done, n);
        end
    endtask

    // Starting at a frame_done cycle, checks the following 40 cycles against
    // the expected display of the given frame data.
    task automatic check_frame(input string name, input logic [15:0] val,
                               input logic [3:0] dpv, input logic [3:0] en,
                               input logic blz);
        int    bad [4];
        string first [4];
        for (int k = 0; k < 4; k++) begin
            bad[k]   = 0;
            first[k] = "";
        end
        for (int j = 1; j <= 40; j++) begin
            int         k, p;
            logic       lit, exp_dp, exp_fd;
            logic [3:0] exp_an, nib;
            logic [6:0] exp_seg;
            @(negedge clk);
            if (j == 1) begin
                bus.load = 1'b0;
                checks++;
                if (bus.pending !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_pending_clear: pending=%b required 0", name, bus.pending);
                end
            end
            k   = (j - 1) / 10;
            p   = (j - 1) % 10;
            nib = val[4*k +: 4];
            lit = en[k] && !(blz && k > 0 && ((val >> (4*k)) == 16'h0));
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            if (lit && p >= 2) begin
                exp_an  = ~(4'b0001 << k);
                exp_seg = ~HEX_SHAPE[nib];
                exp_dp  = ~dpv[k];
            end
            exp_fd = (j == 40);
            if (an !== exp_an || seg_obs !== exp_seg || dp !== exp_dp ||
                bus.frame_done !== exp_fd) begin
                if (bad[k] == 0)
                    first[k] = $sformatf("cycle %0d AN=%b seg=%h dp=%b fd=%b required AN=%b seg=%h dp=%b fd=%b",
                                         j, an, seg_obs, dp, bus.frame_done,
                                         exp_an, exp_seg, exp_dp, exp_fd);
                bad[k]++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bad[k] != 0) begin
                failures++;
                $display("FAIL %s_digit%0d: %0d bad cycles, first %s", name, k, bad[k], first[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.digit_en = '0;
        bus.blank_lz = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (an !== 4'hF) begin failures++; $display("FAIL reset_an: AN=%b required 1111", an); end
        checks++;
        if (seg_obs !== 7'h7F) begin failures++; $display("FAIL reset_seg: seg=%h required 7f", seg_obs); end
        checks++;
        if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: DP=%b required 1", dp); end
        checks++;
        if (bus.pending !== 1'b0) begin failures++; $display("FAIL reset_pending: pending=%b required 0", bus.pending); end
        checks++;
        if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: frame_done=%b required 0", bus.frame_done); end
    endtask

    task automatic test_basic();
        int   n;
        logic saw;
        rst_n = 1'b1;
        set_load(16'h1234, 4'b0010, 4'hF, 1'b0);
        @(negedge clk);
        bus.load = 1'b0;
        checks++;
        if (bus.pending !== 1'b1) begin failures++; $display("FAIL basic_pending_set: pending=%b required 1", bus.pending); end
        wait_frame_done(n, saw);
        checks++;
        if (n != 38) begin failures++; $display("FAIL basic_first_frame_len: waited %0d required 38", n); end
        checks++;
        if (saw !== 1'b0) begin failures++; $display("FAIL basic_dark_before_swap: lit=%b required 0", saw); end
        checks++;
        if (bus.pending !== 1'b1) begin failures++; $display("FAIL basic_pending_at_fd: pending=%b required 1", bus.pending); end
        check_frame("basic", 16'h1234, 4'b0010, 4'hF, 1'b0);
    endtask

    task automatic test_load_on_frame_done();
        set_load(16'h89EF, 4'b0000, 4'hF, 1'b0);
        check_frame("load_on_fd", 16'h89EF, 4'b0000, 4'hF, 1'b0);
    endtask

    task automatic test_blanking();
        set_load(16'h00A0, 4'b0000, 4'hF, 1'b1);
        check_frame("lz_00a0", 16'h00A0, 4'b0000, 4'hF, 1'b1);
        set_load(16'h0000, 4'b0000, 4'hF, 1'b1);
        check_frame("lz_zero", 16'h0000, 4'b0000, 4'hF, 1'b1);
        set_load(16'h1234, 4'b0000, 4'b1010, 1'b0);
        check_frame("digit_en", 16'h1234, 4'b0000, 4'b1010, 1'b0);
    endtask

    task automatic test_back_to_back();
        fork
            check_frame("hold_old", 16'h1234, 4'b0000, 4'b1010, 1'b0);
            begin
                repeat (5) @(negedge clk);
                set_load(16'h1111, 4'hF, 4'hF, 1'b0);
                @(negedge clk);
                bus.load = 1'b0;
                checks++;
                if (bus.pending !== 1'b1) begin failures++; $display("FAIL b2b_pending_first: pending=%b required 1", bus.pending); end
                repeat (14) @(negedge clk);
                set_load(16'h2222, 4'h0, 4'hF, 1'b0);
                @(negedge clk);
                bus.load = 1'b0;
                repeat (9) @(negedge clk);
                checks++;
                if (bus.pending !== 1'b1) begin failures++; $display("FAIL b2b_pending_second: pending=%b required 1", bus.pending); end
            end
        join
        checks++;
        if (bus.pending !== 1'b1) begin failures++; $display("FAIL b2b_pending_at_fd: pending=%b required 1", bus.pending); end
        check_frame("last_load_wins", 16'h2222, 4'h0, 4'hF, 1'b0);
    endtask

    task automatic test_reset_mid();
        int   n;
        logic saw;
        repeat (5) @(negedge clk);
        set_load(16'h9999, 4'hF, 4'hF, 1'b0);
        @(negedge clk);
        bus.load = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (an !== 4'b1101) begin failures++; $display("FAIL mid_pre_reset_an: AN=%b required 1101", an); end
        checks++;
        if (bus.pending !== 1'b1) begin failures++; $display("FAIL mid_pre_reset_pending: pending=%b required 1", bus.pending); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF) begin failures++; $display("FAIL mid_reset_an: AN=%b required 1111", an); end
        checks++;
        if (seg_obs !== 7'h7F) begin failures++; $display("FAIL mid_reset_seg: seg=%h required 7f", seg_obs); end
        checks++;
        if (dp !== 1'b1) begin failures++; $display("FAIL mid_reset_dp: DP=%b required 1", dp); end
        checks++;
        if (bus.pending !== 1'b0) begin failures++; $display("FAIL mid_reset_pending: pending=%b required 0", bus.pending); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_load(16'h4321, 4'b0001, 4'hF, 1'b0);
        @(negedge clk);
        bus.load = 1'b0;
        wait_frame_done(n, saw);
        checks++;
        if (n != 38) begin failures++; $display("FAIL mid_restart_frame_len: waited %0d required 38", n); end
        checks++;
        if (saw !== 1'b0) begin failures++; $display("FAIL mid_active_cleared: lit=%b required 0", saw); end
        check_frame("after_reset", 16'h4321, 4'b0001, 4'hF, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_on_frame_done();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
